bsg_xor_rr_share: RTL and testbench
===================================

BSG_XOR_RR_SHARE -- requirements
Module: bsg_xor_rr_share

Interface
REQ-001 SHALL have parameter width_p, default 32, XOR operand/result width in bits (legal range 1..64).
REQ-002 SHALL have parameter count_width_p, default 16, width of the completed-operation counter.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports r0_v_i / r1_v_i  input  1 each  requester 0/1 operation valid.
REQ-006 SHALL have ports r0_a_i, r0_b_i / r1_a_i, r1_b_i  input  width_p each  requester operands.
REQ-007 SHALL have ports r0_yumi_o / r1_yumi_o  output  1 each  operation of that requester consumed this cycle.
REQ-008 SHALL have port v_o  output  1  result register holds a valid result.
REQ-009 SHALL have port data_o  output  width_p  registered bitwise XOR result.
REQ-010 SHALL have port tag_o  output  1  requester index (0/1) owning data_o.
REQ-011 SHALL have port ready_i  input  1  downstream accepts result when v_o & ready_i.
REQ-012 SHALL have port ops_o  output  count_width_p  count of results accepted downstream.

Function
REQ-013 SHALL share one width_p-bit XOR datapath between two requesters.
REQ-014 Input handshake SHALL be valid-yumi: requester holds v/operands stable until its yumi_o pulses; yumi_o may depend combinationally on v_i, ready_i, and state only.
REQ-015 Slot free SHALL be defined as (~v_o) | ready_i.
REQ-016 At most one yumi_o SHALL assert per cycle; rX_yumi_o = slot_free & rX_v_i & grant_X.
REQ-017 Grant: one valid requester -> that requester; both valid -> requester selected by priority pointer; none -> no grant.
REQ-018 Priority pointer (1 bit) SHALL toggle to the non-granted requester only on a cycle with a yumi; otherwise it holds.
REQ-019 On a yumi cycle, next cycle: v_o=1, data_o=a^b of the granted requester, tag_o=granted index (latency 1 cycle).
REQ-020 On a cycle with v_o & ready_i and no yumi, next cycle v_o=0; data_o and tag_o hold their last values.
REQ-021 With v_o=1 & ready_i=0, v_o/data_o/tag_o SHALL hold and no yumi_o SHALL assert.
REQ-022 Simultaneous downstream accept and new grant SHALL replace the result with no bubble (full throughput: one op/cycle).
REQ-023 ops_o SHALL increment by 1 on each cycle with v_o & ready_i, wrapping from 2^count_width_p-1 to 0.
REQ-024 Requester deasserting v_i without receiving yumi is a protocol violation; behaviour is unspecified but SHALL NOT corrupt a held result.
REQ-025 XOR SHALL be purely bitwise, no carries; width_p bits in, width_p bits out.

Reset
REQ-026 Asserting reset_i SHALL immediately (without a clock) force v_o=0, data_o=0, tag_o=0, ops_o=0, priority pointer=0.
REQ-027 While reset_i=1, r0_yumi_o and r1_yumi_o SHALL be 0.
REQ-028 Reset mid-transfer SHALL discard the held result; no op is counted; first grant after release follows pointer=0.

Verification
REQ-029 After reset, r0_v_i=1, a=0xFFFF0000, b=0x0F0F0F0F, ready_i=1 -> r0_yumi_o=1 same cycle; next cycle v_o=1, data_o=0xF0F00F0F, tag_o=0; ops_o=1 one cycle later.
REQ-030 Both requesters valid continuously, ready_i=1 -> yumi alternates r0,r1,r0,r1; tag_o sequence 0,1,0,1 with v_o held 1 (no bubbles).
REQ-031 Result held with ready_i=0 for 5 cycles while both requesters valid -> no yumi_o, data_o/tag_o stable, ops_o unchanged; ready_i=1 -> next grant same cycle.
REQ-032 Only r1 valid for 3 ops, then both valid -> r1 served 3 times, next grant goes to r0 (pointer toggled to 0 after each r1 grant).
REQ-033 count_width_p=4, 17 accepted results -> ops_o wraps 15->0 and reads 1.
REQ-034 reset_i pulsed asynchronously between clock edges while v_o=1 -> v_o, data_o, tag_o, ops_o read 0 before next edge; no yumi_o during reset.

Source files
------------

// File: rtl/bsg_xor_rr_share.sv
// bsg_xor_rr_share: one registered XOR datapath shared by two valid/yumi
// requesters. A round-robin arbiter picks the requester, and a one-deep result
// register presents the output to a valid/ready consumer. A wrapping counter
// tallies the results that the consumer accepts.
module bsg_xor_rr_share #(
  parameter int width_p       = 32,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     r0_v_i,
  input  logic [width_p-1:0]       r0_a_i,
  input  logic [width_p-1:0]       r0_b_i,
  output logic                     r0_yumi_o,

  input  logic                     r1_v_i,
  input  logic [width_p-1:0]       r1_a_i,
  input  logic [width_p-1:0]       r1_b_i,
  output logic                     r1_yumi_o,

  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic                     tag_o,
  input  logic                     ready_i,

  output logic [count_width_p-1:0] ops_o
);

  logic                     v_q, v_d;
  logic [width_p-1:0]       data_q, data_d;
  logic                     tag_q, tag_d;
  logic                     ptr_q, ptr_d;
  logic [count_width_p-1:0] ops_q, ops_d;

  logic                     slot_free;
  logic                     grant_idx;
  logic                     yumi;
  logic [width_p-1:0]       xor_result;

  // Arbitrate, pick operands for the shared XOR, and work out next state.
  // The result register is free when empty or when being drained this cycle,
  // which lets a new op replace an accepted one with no bubble. Yumi is
  // suppressed while reset is asserted so no op is consumed and then lost.
  always_comb begin
    slot_free  = (~v_q) | ready_i;

    if (r0_v_i & r1_v_i) begin
      grant_idx = ptr_q;
    end else if (r1_v_i) begin
      grant_idx = 1'b1;
    end else begin
      grant_idx = 1'b0;
    end

    yumi       = slot_free & (r0_v_i | r1_v_i) & ~reset_i;
    r0_yumi_o  = yumi & ~grant_idx;
    r1_yumi_o  = yumi & grant_idx;

    xor_result = grant_idx ? (r1_a_i ^ r1_b_i) : (r0_a_i ^ r0_b_i);

    v_d    = v_q;
    data_d = data_q;
    tag_d  = tag_q;
    ptr_d  = ptr_q;
    ops_d  = ops_q;

    if (v_q & ready_i) begin
      v_d   = 1'b0;
      ops_d = ops_q + count_width_p'(1);
    end

    if (yumi) begin
      v_d    = 1'b1;
      data_d = xor_result;
      tag_d  = grant_idx;
      ptr_d  = ~grant_idx;
    end
  end

  // Result register, priority pointer and accept counter; reset clears all.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      tag_q  <= 1'b0;
      ptr_q  <= 1'b0;
      ops_q  <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      tag_q  <= tag_d;
      ptr_q  <= ptr_d;
      ops_q  <= ops_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
  assign tag_o  = tag_q;
  assign ops_o  = ops_q;

endmodule

// File: tb/tb_bsg_xor_rr_share.sv
// Directed bench for bsg_xor_rr_share: a 32-bit/16-bit-counter instance for
// the arbitration, handshake and reset behaviour, plus an 8-bit/4-bit-counter
// instance for counter wrap. Expected values are written out by hand.
module tb_bsg_xor_rr_share;

  logic        clk_i;
  logic        reset_i;

  logic        r0_v_i, r1_v_i, ready_i;
  logic [31:0] r0_a_i, r0_b_i, r1_a_i, r1_b_i;
  logic        r0_yumi_o, r1_yumi_o, v_o, tag_o;
  logic [31:0] data_o;
  logic [15:0] ops_o;

  logic        s_r0_v, s_r1_v, s_ready;
  logic [7:0]  s_r0_a, s_r0_b, s_r1_a, s_r1_b;
  logic        s_r0_yumi, s_r1_yumi, s_v, s_tag;
  logic [7:0]  s_data;
  logic [3:0]  s_ops;

  int total_checks;
  int passed_checks;

  bsg_xor_rr_share #(.width_p(32), .count_width_p(16)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .r0_v_i    (r0_v_i),
    .r0_a_i    (r0_a_i),
    .r0_b_i    (r0_b_i),
    .r0_yumi_o (r0_yumi_o),
    .r1_v_i    (r1_v_i),
    .r1_a_i    (r1_a_i),
    .r1_b_i    (r1_b_i),
    .r1_yumi_o (r1_yumi_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .tag_o     (tag_o),
    .ready_i   (ready_i),
    .ops_o     (ops_o)
  );

  bsg_xor_rr_share #(.width_p(8), .count_width_p(4)) dut_small (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .r0_v_i    (s_r0_v),
    .r0_a_i    (s_r0_a),
    .r0_b_i    (s_r0_b),
    .r0_yumi_o (s_r0_yumi),
    .r1_v_i    (s_r1_v),
    .r1_a_i    (s_r1_a),
    .r1_b_i    (s_r1_b),
    .r1_yumi_o (s_r1_yumi),
    .v_o       (s_v),
    .data_o    (s_data),
    .tag_o     (s_tag),
    .ready_i   (s_ready),
    .ops_o     (s_ops)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // One comparison: count it, and report a mismatch with tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkResult(input string tag, input logic ev, input logic [31:0] ed,
                             input logic et, input logic [15:0] eo);
    checkOutput({tag, ".v"},    {63'd0, v_o},   {63'd0, ev});
    checkOutput({tag, ".data"}, {32'd0, data_o}, {32'd0, ed});
    checkOutput({tag, ".tag"},  {63'd0, tag_o}, {63'd0, et});
    checkOutput({tag, ".ops"},  {48'd0, ops_o}, {48'd0, eo});
  endtask

  task automatic checkYumi(input string tag, input logic e0, input logic e1);
    checkOutput({tag, ".yumi0"}, {63'd0, r0_yumi_o}, {63'd0, e0});
    checkOutput({tag, ".yumi1"}, {63'd0, r1_yumi_o}, {63'd0, e1});
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;

    reset_i = 1'b0;
    r0_v_i = 1'b1; r1_v_i = 1'b1; ready_i = 1'b1;
    r0_a_i = 32'h0; r0_b_i = 32'h0; r1_a_i = 32'h0; r1_b_i = 32'h0;
    s_r0_v = 1'b0; s_r1_v = 1'b0; s_ready = 1'b0;
    s_r0_a = 8'h0; s_r0_b = 8'h0; s_r1_a = 8'h0; s_r1_b = 8'h0;

    // Reset state, and no yumi while reset is held even with requests pending.
    #1 reset_i = 1'b1;
    #2;
    checkResult("reset", 1'b0, 32'h0, 1'b0, 16'd0);
    checkYumi("reset", 1'b0, 1'b0);
    tick();
    checkYumi("reset_edge", 1'b0, 1'b0);
    checkResult("reset_edge", 1'b0, 32'h0, 1'b0, 16'd0);

    // Single request from r0: yumi in the same cycle, result one cycle later.
    #1;
    reset_i = 1'b0;
    r1_v_i  = 1'b0;
    r0_a_i  = 32'hFFFF0000; r0_b_i = 32'h0F0F0F0F;
    #1;
    checkYumi("single_r0", 1'b1, 1'b0);
    tick();
    checkResult("single_r0_res", 1'b1, 32'hF0F00F0F, 1'b0, 16'd0);
    r0_v_i = 1'b0;
    #1;
    checkYumi("idle", 1'b0, 1'b0);
    tick();
    checkResult("drain", 1'b0, 32'hF0F00F0F, 1'b0, 16'd1);

    // Fill the register from r0 (pointer moves to 1), then reset mid-cycle.
    r0_v_i = 1'b1; r0_a_i = 32'h00000055; r0_b_i = 32'h000000AA;
    #1;
    checkYumi("pre_areset", 1'b1, 1'b0);
    tick();
    checkResult("pre_areset_res", 1'b1, 32'h000000FF, 1'b0, 16'd1);
    r0_v_i = 1'b0; ready_i = 1'b0;
    #1;
    reset_i = 1'b1;
    r0_v_i  = 1'b1; r1_v_i = 1'b1; ready_i = 1'b1;
    #1;
    checkResult("areset", 1'b0, 32'h0, 1'b0, 16'd0);
    checkYumi("areset", 1'b0, 1'b0);
    reset_i = 1'b0;

    // Both requesters continuously valid: r0 first (pointer cleared), then alternate.
    r0_a_i = 32'h00000001; r0_b_i = 32'h00000002;
    r1_a_i = 32'h00000030; r1_b_i = 32'h00000003;
    #1;
    checkYumi("rr_first", 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkResult($sformatf("rr%0d", k), 1'b1,
                  (k % 2 == 1) ? 32'h00000033 : 32'h00000003,
                  (k % 2 == 1), 16'(k));
      checkYumi($sformatf("rr%0d", k), (k % 2 == 1), (k % 2 == 0));
    end

    // Downstream stalls five cycles: everything holds, nothing consumed.
    ready_i = 1'b0;
    #1;
    checkYumi("stall", 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkResult($sformatf("stall%0d", k), 1'b1, 32'h00000033, 1'b1, 16'd3);
      checkYumi($sformatf("stall%0d", k), 1'b0, 1'b0);
    end
    ready_i = 1'b1;
    #1;
    checkYumi("unstall", 1'b1, 1'b0);
    tick();
    checkResult("unstall_res", 1'b1, 32'h00000003, 1'b0, 16'd4);

    // Only r1 valid for three ops, then both: r0 must win next.
    r0_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r1_a_i = 32'(i + 1); r1_b_i = 32'h000000F0;
      #1;
      checkYumi($sformatf("r1only%0d", i), 1'b0, 1'b1);
      tick();
      checkResult($sformatf("r1only%0d", i), 1'b1, 32'h000000F1 + 32'(i), 1'b1,
                  16'(5 + i));
    end
    r0_v_i = 1'b1;
    #1;
    checkYumi("after_r1", 1'b1, 1'b0);
    tick();
    checkResult("after_r1_res", 1'b1, 32'h00000003, 1'b0, 16'd8);

    // Accept with no new op: valid drops, data and tag hold.
    r0_v_i = 1'b0; r1_v_i = 1'b0;
    #1;
    checkYumi("final_idle", 1'b0, 1'b0);
    tick();
    checkResult("final_drain", 1'b0, 32'h00000003, 1'b0, 16'd9);

    // Small instance: 17 accepted results wrap a 4-bit counter to 1.
    s_r0_v = 1'b1; s_ready = 1'b1; s_r0_a = 8'hA5; s_r0_b = 8'h0F;
    for (int n = 1; n <= 18; n++) begin
      tick();
      if (n == 1) begin
        checkOutput("wrap_data", {56'd0, s_data}, {56'd0, 8'hAA});
        checkOutput("wrap_tag",  {63'd0, s_tag},  64'd0);
        checkOutput("wrap_y1",   {63'd0, s_r1_yumi}, 64'd0);
        checkOutput("wrap_y0",   {63'd0, s_r0_yumi}, 64'd1);
      end
      if (n == 16) checkOutput("wrap_ops15", {60'd0, s_ops}, 64'd15);
      if (n == 17) checkOutput("wrap_ops0",  {60'd0, s_ops}, 64'd0);
      if (n == 18) begin
        checkOutput("wrap_ops1", {60'd0, s_ops}, 64'd1);
        checkOutput("wrap_v",    {63'd0, s_v},   64'd1);
      end
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
